// File: rtl/neuron_if.sv
// neuron_if: grouped handshake channels between a neuron and its neighbours
interface neuron_if #(
  parameter int N = 4
);
  logic             inp_stb, inp_rdy;
  logic [8*N-1:0]   inp_dat;
  logic             arg_stb, arg_rdy;
  logic [15:0]      arg_dat;
  logic             res_stb, res_rdy;
  logic [7:0]       res_dat;
  logic             out_stb, out_rdy;
  logic [7:0]       out_dat;
  logic             bwd_stb, bwd_rdy;
  logic [15:0]      bwd_dat;
  logic             err_stb, err_rdy;
  logic [15:0]      err_dat;
  logic             fbk_stb, fbk_rdy;
  logic [15:0]      fbk_dat;
  modport master (
    input  inp_stb, inp_dat, output inp_rdy,
    output arg_stb, arg_dat, input  arg_rdy,
    input  res_stb, res_dat, output res_rdy,
    output out_stb, out_dat, input  out_rdy,
    input  bwd_stb, bwd_dat, output bwd_rdy,
    output err_stb, err_dat, input  err_rdy,
    input  fbk_stb, fbk_dat, output fbk_rdy
  );
  modport slave (
    output inp_stb, inp_dat, input  inp_rdy,
    input  arg_stb, arg_dat, output arg_rdy,
    output res_stb, res_dat, input  res_rdy,
    input  out_stb, out_dat, output out_rdy,
    output bwd_stb, bwd_dat, input  bwd_rdy,
    input  err_stb, err_dat, output err_rdy,
    output fbk_stb, fbk_dat, input  fbk_rdy
  );
endinterface

// File: rtl/neuron.sv
// neuron: weighted-sum node driving an activation unit, with optional weight training
module neuron #(
  parameter int                 N           = 4,
  parameter logic signed [15:0] WEIGHT_INIT = 16'sh0100,
  parameter int                 RATE_SHIFT  = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  neuron_if.master  bus
);
  localparam int AW = 26 + $clog2(N);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [3:0] {INP, MAC, ARG, RES, OUT, ERR, AER, FBK, UPD} state_t;
  state_t                state, nxt;
  logic [IW-1:0]         idx;
  logic [7:0]            x [N];
  logic signed [15:0]    w [N];
  logic signed [AW-1:0]  acc, xs, term, upd;
  logic [15:0]           arg_r, e, d;
  logic [7:0]            y;
  logic                  last, inp_ack, arg_ack, res_ack, out_ack, bwd_ack, err_ack, fbk_ack;
  function automatic logic [15:0] sat16(input logic signed [AW-1:0] v);
    return v > AW'(32767) ? 16'h7fff : v < -AW'(32768) ? 16'h8000 : v[15:0];
  endfunction
  assign last    = idx == IW'(N - 1);
  assign xs      = AW'($signed({1'b0, x[idx]}));
  assign term    = (AW'(w[idx]) * xs) >>> 8;
  assign upd     = AW'(w[idx]) + ((AW'($signed(d)) * xs) >>> (8 + RATE_SHIFT));
  assign inp_ack = bus.inp_stb & bus.inp_rdy;
  assign arg_ack = bus.arg_stb & bus.arg_rdy;
  assign res_ack = bus.res_stb & bus.res_rdy;
  assign out_ack = bus.out_stb & bus.out_rdy;
  assign bwd_ack = bus.bwd_stb & bus.bwd_rdy;
  assign err_ack = bus.err_stb & bus.err_rdy;
  assign fbk_ack = bus.fbk_stb & bus.fbk_rdy;
  assign bus.inp_rdy = state == INP;
  assign bus.arg_stb = state == ARG;
  assign bus.res_rdy = state == RES;
  assign bus.out_stb = state == OUT;
  assign bus.bwd_rdy = state == ERR;
  assign bus.err_stb = state == AER;
  assign bus.fbk_rdy = state == FBK;
  assign bus.arg_dat = arg_r;
  assign bus.out_dat = y;
  assign bus.err_dat = e;
  // next state: advance only on the active channel's handshake or the last index
  always_comb begin
    nxt = state;
    case (state)
      INP:     nxt = inp_ack ? MAC : INP;
      MAC:     nxt = last ? ARG : MAC;
      ARG:     nxt = arg_ack ? RES : ARG;
      RES:     nxt = res_ack ? OUT : RES;
      OUT:     nxt = out_ack ? (en ? ERR : INP) : OUT;
      ERR:     nxt = bwd_ack ? AER : ERR;
      AER:     nxt = err_ack ? FBK : AER;
      FBK:     nxt = fbk_ack ? UPD : FBK;
      UPD:     nxt = last ? INP : UPD;
      default: nxt = INP;
    endcase
  end
  // state register plus datapath: capture, accumulate, and per-weight update
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INP;
      idx   <= '0;
      acc   <= '0;
      arg_r <= '0;
      y     <= '0;
      e     <= '0;
      d     <= '0;
      for (int i = 0; i < N; i++) begin
        x[i] <= '0;
        w[i] <= WEIGHT_INIT;
      end
    end else begin
      state <= nxt;
      case (state)
        INP: if (inp_ack) begin
          for (int i = 0; i < N; i++) x[i] <= bus.inp_dat[8*i +: 8];
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          acc <= acc + term;
          idx <= last ? '0 : idx + IW'(1);
          if (last) arg_r <= sat16(acc + term);
        end
        RES: if (res_ack) y <= bus.res_dat;
        ERR: if (bwd_ack) e <= bus.bwd_dat;
        FBK: if (fbk_ack) d <= bus.fbk_dat;
        UPD: begin
          w[idx] <= sat16(upd);
          idx    <= last ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron.sv
// tb_neuron: directed passes with a scoreboard; three lockstep instances cover nominal and saturating weights
module tb_neuron;
  localparam int N  = 4;
  localparam int RS = 4;
  logic clk = 0, rst = 1, en_r = 0;
  logic inp_stb = 0, arg_rdy = 0, res_stb = 0, out_rdy = 0, bwd_stb = 0, err_rdy = 0, fbk_stb = 0;
  logic [8*N-1:0] inp_dat = '0;
  logic [7:0]     res_dat = '0;
  logic [15:0]    bwd_dat = '0, fbk_dat = '0;
  int n_cmp = 0, n_bad = 0, bad_inf = 0;
  logic inf_chk = 0;
  logic signed [15:0] wm [N];
  logic [15:0] arg_q [$];
  logic [7:0]  out_q [$];

  always #5 clk = ~clk;

  neuron_if #(.N(N)) b [3] ();

  for (genvar g = 0; g < 3; g++) begin : u
    assign b[g].inp_stb = inp_stb;
    assign b[g].inp_dat = inp_dat;
    assign b[g].arg_rdy = arg_rdy;
    assign b[g].res_stb = res_stb;
    assign b[g].res_dat = res_dat;
    assign b[g].out_rdy = out_rdy;
    assign b[g].bwd_stb = bwd_stb;
    assign b[g].bwd_dat = bwd_dat;
    assign b[g].err_rdy = err_rdy;
    assign b[g].fbk_stb = fbk_stb;
    assign b[g].fbk_dat = fbk_dat;
    neuron #(
      .N(N),
      .WEIGHT_INIT(g == 0 ? 16'sh0100 : g == 1 ? 16'sh7fff : 16'sh8000),
      .RATE_SHIFT(RS)
    ) dut (
      .clk(clk),
      .rst(rst),
      .en(en_r),
      .bus(b[g])
    );
  end

  always @(negedge clk)
    if (inf_chk && (b[0].bwd_rdy || b[0].err_stb || b[0].fbk_rdy)) bad_inf++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input longint v);
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
  endfunction

  function automatic logic [15:0] fwd(input logic [7:0] x);
    longint a = 0;
    for (int i = 0; i < N; i++) a += (longint'(wm[i]) * longint'(x)) >>> 8;
    return sat(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) wm[i] = 16'sh0100;
  endtask

  task automatic do_pass(input logic [7:0] x, input logic tr, input logic [7:0] y,
                         input logic [15:0] bw, input logic [15:0] fb,
                         input int sa, input int so, input logic ru);
    logic [15:0] ea;
    logic [7:0]  eo;
    int snap;
    snap = bad_inf;
    en_r = tr;
    inf_chk = !tr;
    chk("inp_rdy_idle", 32'(b[0].inp_rdy), 1);
    inp_dat = {N{x}};
    inp_stb = 1;
    arg_q.push_back(fwd(x));
    @(negedge clk);
    inp_stb = 0;
    chk("inp_rdy_busy", 32'(b[0].inp_rdy), 0);
    repeat (N - 1) @(negedge clk);
    chk("arg_stb_early", 32'(b[0].arg_stb), 0);
    @(negedge clk);
    chk("arg_stb", 32'(b[0].arg_stb), 1);
    if (x == 8'hff) begin
      chk("sat_hi", 32'(b[1].arg_dat), 'h7fff);
      chk("sat_lo", 32'(b[2].arg_dat), 'h8000);
    end
    ea = arg_q[0];
    for (int k = 0; k < sa; k++) begin
      chk("arg_hold_stb", 32'(b[0].arg_stb), 1);
      chk("arg_hold_dat", 32'(b[0].arg_dat), 32'(ea));
      chk("res_rdy_stall", 32'(b[0].res_rdy), 0);
      @(negedge clk);
    end
    arg_rdy = 1;
    chk("arg_dat", 32'(b[0].arg_dat), 32'(arg_q.pop_front()));
    @(negedge clk);
    arg_rdy = 0;
    chk("arg_once", 32'(b[0].arg_stb), 0);
    chk("res_rdy", 32'(b[0].res_rdy), 1);
    res_dat = y;
    res_stb = 1;
    out_q.push_back(y);
    @(negedge clk);
    res_stb = 0;
    res_dat = 8'h00;
    chk("out_stb", 32'(b[0].out_stb), 1);
    eo = out_q[0];
    for (int k = 0; k < so; k++) begin
      chk("out_hold_stb", 32'(b[0].out_stb), 1);
      chk("out_hold_dat", 32'(b[0].out_dat), 32'(eo));
      chk("inp_rdy_stall", 32'(b[0].inp_rdy), 0);
      @(negedge clk);
    end
    out_rdy = 1;
    chk("out_dat", 32'(b[0].out_dat), 32'(out_q.pop_front()));
    @(negedge clk);
    out_rdy = 0;
    chk("out_once", 32'(b[0].out_stb), 0);
    if (!tr) begin
      chk("inp_rdy_after_out", 32'(b[0].inp_rdy), 1);
      chk("no_train_chan", 32'(bad_inf), 32'(snap));
    end else begin
      chk("bwd_rdy", 32'(b[0].bwd_rdy), 1);
      bwd_dat = bw;
      bwd_stb = 1;
      @(negedge clk);
      bwd_stb = 0;
      chk("err_stb", 32'(b[0].err_stb), 1);
      chk("err_dat", 32'(b[0].err_dat), 32'(bw));
      err_rdy = 1;
      @(negedge clk);
      err_rdy = 0;
      chk("err_once", 32'(b[0].err_stb), 0);
      chk("fbk_rdy", 32'(b[0].fbk_rdy), 1);
      fbk_dat = fb;
      fbk_stb = 1;
      @(negedge clk);
      fbk_stb = 0;
      if (ru) begin
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        chk("rst_inp_rdy", 32'(b[0].inp_rdy), 1);
        chk("rst_arg_stb", 32'(b[0].arg_stb), 0);
        chk("rst_out_dat", 32'(b[0].out_dat), 0);
      end else begin
        for (int i = 0; i < N; i++)
          wm[i] = sat(longint'(wm[i]) + ((longint'($signed(fb)) * longint'(x)) >>> (8 + RS)));
        repeat (N - 1) @(negedge clk);
        chk("upd_busy", 32'(b[0].inp_rdy), 0);
        @(negedge clk);
        chk("upd_done", 32'(b[0].inp_rdy), 1);
      end
    end
    inf_chk = 0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_inp_rdy", 32'(b[0].inp_rdy), 1);
    chk("rst_stb", 32'({b[0].arg_stb, b[0].out_stb, b[0].err_stb}), 0);
    chk("rst_rdy", 32'({b[0].res_rdy, b[0].bwd_rdy, b[0].fbk_rdy}), 0);
    chk("rst_data", 32'({b[0].arg_dat, b[0].out_dat}), 0);
    chk("rst_err_dat", 32'(b[0].err_dat), 0);
    do_pass(8'hff, 0, 8'h11, 16'h0000, 16'h0000, 0, 0, 0);
    do_pass(8'h40, 0, 8'hb0, 16'h0000, 16'h0000, 0, 0, 0);
    chk("fwd_expect", 32'(fwd(8'h40)), 'h0100);
    do_pass(8'h40, 0, 8'h5a, 16'h0000, 16'h0000, 3, 3, 0);
    do_pass(8'h80, 1, 8'h77, 16'h0123, 16'h0100, 0, 0, 0);
    for (int i = 0; i < N; i++) chk("model_w", 32'(wm[i]), 'h0108);
    do_pass(8'h40, 0, 8'h3c, 16'h0000, 16'h0000, 0, 0, 0);
    do_pass(8'h80, 1, 8'h21, 16'h0123, 16'h0100, 0, 0, 1);
    do_pass(8'h40, 0, 8'hc4, 16'h0000, 16'h0000, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron.md
# neuron

Single processing node for the machina datapath, acting as the initiator of the activation unit's four-channel protocol. It accepts a vector of N unsigned 8-bit activations from the previous layer and forms a saturated Q8.8 weighted sum. It sends that sum to the activation unit as the argument and forwards the returned 8-bit result downstream. When training is enabled, it takes the downstream error, routes it through the activation unit's error/feedback channels, and applies the returned delta as an update to its internal weights.

## Interface
- N, 4, number of inputs/weights (≥1)
- WEIGHT_INIT, 16'sh0100, reset value of every weight (signed Q8.8)
- RATE_SHIFT, 4, learning-rate right shift applied to weight updates
- clk  in  1  clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- en  in  1  training enable; sampled at out_ack; held stable from inp_ack until return to INP
- inp_stb / inp_dat / inp_rdy  in/in/out  1/8*N/1  input vector; element i at [8i+7:8i], unsigned Q0.8
- arg_stb / arg_dat / arg_rdy  out/out/in  1/16/1  argument to activation, signed Q8.8
- res_stb / res_dat / res_rdy  in/in/out  1/8/1  activation result
- out_stb / out_dat / out_rdy  out/out/in  1/8/1  result to next layer
- bwd_stb / bwd_dat / bwd_rdy  in/in/out  1/16/1  error from next layer, signed
- err_stb / err_dat / err_rdy  out/out/in  1/16/1  error to activation
- fbk_stb / fbk_dat / fbk_rdy  in/in/out  1/16/1  delta from activation, signed

## Operation
- Handshake: xxx_ack = stb & rdy. A transfer occurs on the clock edge with ack high.
- Every stb/rdy output is decoded from the state register. Data outputs come from registers and are stable while stb is high.
- States and transitions:
  - INP: inp_rdy=1. On inp_ack, capture x[0..N-1], clear acc and index, go to MAC.
  - MAC: one product per cycle for i=0..N-1, acc += (w[i]*$signed({1'b0,x[i]})) >>> 8. After i=N-1, go to ARG.
  - ARG: arg_stb=1, arg_dat=sat16(acc). On arg_ack, go to RES.
  - RES: res_rdy=1. On res_ack, capture y, go to OUT.
  - OUT: out_stb=1, out_dat=y. On out_ack, go to ERR if en, else INP.
  - ERR: bwd_rdy=1. On bwd_ack, capture e, go to AER.
  - AER: err_stb=1, err_dat=e. On err_ack, go to FBK.
  - FBK: fbk_rdy=1. On fbk_ack, capture d, go to UPD.
  - UPD: one weight per cycle for i=0..N-1, w[i] <= sat16(w[i] + ((d*$signed({1'b0,x[i]})) >>> (8+RATE_SHIFT))). After i=N-1, go to INP.
- Arithmetic:
  - acc is wide enough for N full-scale products (≥ 24+clog2(N) bits), so it never overflows internally.
  - sat16 clamps to [16'sh8000, 16'sh7fff].
  - All shifts are arithmetic (floor). No rounding.
- Captured x is held through UPD, so weight updates use the inputs of the same forward pass.
- Back-propagation of error to the previous layer is out of scope.

## Timing
- Reset (any state): state=INP, index=0, acc=0, all w[i]=WEIGHT_INIT.
  - All stb outputs are 0 and all data outputs are 0.
  - inp_rdy=1 on the first cycle after rst deasserts.
  - A transaction in progress is abandoned silently, including a partially completed UPD.
- inp_ack at edge 0 → arg_stb high from edge N+1.
- res_ack → out_stb high the next cycle, so res_dat appears on out_dat with 1-cycle latency.
- out_ack with en=0 → inp_rdy high the next cycle.
- fbk_ack → inp_rdy high N+1 cycles later.
- Each channel completes exactly one transfer per pass. In every state, all stb/rdy signals other than the active channel's are 0.
- Stalls (rdy or stb held low) hold state and all data indefinitely. There is no timeout.
- Inputs on inactive channels are ignored, e.g. res_stb during ARG or bwd_stb during INP.
- Back-to-back passes: inp_rdy may be high on the cycle after out_ack (en=0) or after the last UPD cycle.

## Test plan
- Forward: N=4, reset weights, all x=8'h40, arg_rdy=1.
  - Required: arg_dat=16'h0100 with arg_stb rising 5 cycles after inp_ack.
  - Then return res_dat=8'hB0. Required: out_dat=8'hB0 on the cycle after res_ack.
- Saturation: WEIGHT_INIT=16'sh7fff, all x=8'hFF. Required: arg_dat=16'h7fff.
  - WEIGHT_INIT=16'sh8000, all x=8'hFF. Required: arg_dat=16'h8000.
- Backpressure: hold arg_rdy low 3 cycles, then out_rdy low 3 cycles.
  - Required: stb and data held constant, each channel acked exactly once, no state advance.
- Inference only: en=0. Required: bwd_rdy, err_stb and fbk_rdy never high; inp_rdy high the cycle after out_ack.
- Training: en=1, x=8'h80, bwd_dat=16'h0123, fbk_dat=16'h0100.
  - Required: err_dat=16'h0123; after UPD every w=16'h0108.
  - Next pass with x=8'h40. Required: arg_dat=16'h0108.
- Reset mid-UPD: assert rst for 1 cycle during UPD.
  - Required: inp_rdy=1 the next cycle.
  - A following pass with x=8'h40 gives arg_dat=16'h0100.
